// File: rtl/mesi_isc_broad_fifo.sv
// Show-ahead broadcast request queue between the main controller and the broadcast controller.
// Define MESI_ISC_BROAD_FIFO_ERR_EN to add the sticky overflow/underflow outputs.
module mesi_isc_broad_fifo #(
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 5,
    parameter int FIFO_SIZE_LOG2   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_i,
    input  logic [ADDR_WIDTH-1:0]       broad_addr_i,
    input  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i,
    input  logic [1:0]                  broad_cpu_id_i,
    input  logic [BROAD_ID_WIDTH-1:0]   broad_id_i,
    input  logic                        rd_i,
    output logic [ADDR_WIDTH-1:0]       broad_addr_o,
    output logic [BROAD_TYPE_WIDTH-1:0] broad_type_o,
    output logic [1:0]                  broad_cpu_id_o,
    output logic [BROAD_ID_WIDTH-1:0]   broad_id_o,
    output logic                        fifo_status_empty_o,
    output logic                        fifo_status_full_o,
`ifdef MESI_ISC_BROAD_FIFO_ERR_EN
    output logic                        fifo_overflow_o,
    output logic                        fifo_underflow_o,
`endif
    output logic [FIFO_SIZE_LOG2:0]     fifo_count_o
);

    localparam int DEPTH = 1 << FIFO_SIZE_LOG2;
    localparam int PTR_W = FIFO_SIZE_LOG2;
    localparam int CNT_W = FIFO_SIZE_LOG2 + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]       addr;
        logic [BROAD_TYPE_WIDTH-1:0] btype;
        logic [1:0]                  cpu_id;
        logic [BROAD_ID_WIDTH-1:0]   id;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             push_ok;
    logic             pop_ok;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // A pop in the same cycle frees the slot a push into a full queue needs.
        push_ok = wr_i && (!full_q || rd_i);
        pop_ok  = rd_i && !empty_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = '{addr:   broad_addr_i,
                                btype:  broad_type_i,
                                cpu_id: broad_cpu_id_i,
                                id:     broad_id_i};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_FULL);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: storage is reset too, so the show-ahead head reads 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign broad_addr_o        = mem_q[rd_ptr_q].addr;
    assign broad_type_o        = mem_q[rd_ptr_q].btype;
    assign broad_cpu_id_o      = mem_q[rd_ptr_q].cpu_id;
    assign broad_id_o          = mem_q[rd_ptr_q].id;
    assign fifo_status_empty_o = empty_q;
    assign fifo_status_full_o  = full_q;
    assign fifo_count_o        = count_q;

`ifdef MESI_ISC_BROAD_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Both flags are sticky until reset.
    always_comb begin
        overflow_d  = overflow_q | (wr_i & full_q & ~rd_i);
        underflow_d = underflow_q | (rd_i & empty_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign fifo_overflow_o  = overflow_q;
    assign fifo_underflow_o = underflow_q;
`endif

endmodule
